memory_branch: RTL
==================

// Module: memory_branch
// PURPOSE
//  MB pipeline stage, directly downstream of execute. Consumes the ex_mb__* registers, performs
//  load/store over a req/ack data bus, resolves branches/jumps from alu_zero, and registers the
//  writeback bundle mb_wb__* (consumed by WB and by the execute forwarding unit).
//  Stalls the front of the pipe while a bus access is outstanding.
// PARAMETERS
//  BUS_TIMEOUT   16   max BUSY cycles waiting for dmem_ack before abort (>=1)
// PORTS
//  clk                 in   1   clock, all state on posedge
//  rst                 in   1   asynchronous, active-high reset
//  ex_mb__alu_y        in   32  ALU result / effective address
//  ex_mb__alu_zero     in   1   ALU zero flag
//  ex_mb__pc           in   32  instr PC; 32'hffffffff = bubble (flushed)
//  ex_mb__pc_4         in   32  PC+4 (link value)
//  ex_mb__rs2_rdata    in   32  store data
//  ex_mb__br_target    in   32  branch/jump target
//  ex_mb__br_op        in   2   0 NONE, 1 BEQZ (taken if zero), 2 BNEZ, 3 JUMP
//  ex_mb__mem_op       in   4   0 NONE,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW; 9-15 = NONE
//  ex_mb__rd_src       in   2   0 ALU, 1 MEM, 2 PC_4, 3 ALU
//  ex_mb__rd_addr      in   5   destination register
//  ex_mb__rd_wen       in   1   destination write enable
//  dmem_req            out  1   bus request, held until ack/abort
//  dmem_we             out  1   1 = store
//  dmem_addr           out  32  word-aligned address ({alu_y[31:2],2'b00})
//  dmem_wdata          out  32  lane-replicated store data
//  dmem_be             out  4   byte enables
//  dmem_ack            in   1   access complete; dmem_rdata valid this cycle
//  dmem_rdata          in   32  load word
//  stall               out  1   hold ex_mb__* and all upstream registers
//  pipe_flush          out  1   taken branch/jump, comb, 1 cycle
//  pc_target           out  32  redirect PC, valid with pipe_flush
//  bus_err             out  1   1-cycle pulse: timeout or misaligned trap
//  mb_wb__rd_wdata     out  32  writeback data
//  mb_wb__rd_addr      out  5   writeback register
//  mb_wb__rd_wen       out  1   writeback enable
// BEHAVIOUR
//  - valid = (ex_mb__pc != 32'hffffffff). Invalid: no bus, no flush, mb_wb__rd_wen<=0.
//  - FSM IDLE/BUSY. Reset: IDLE, timeout count 0, every output reg 0 (dmem_* 0, mb_wb__* 0).
//  - IDLE, valid non-mem op: stall=0; next edge mb_wb__* <= {rd_src data, rd_addr, rd_wen&&rd_addr!=0}.
//  - IDLE, valid mem op: stall=1, mb_wb__rd_wen<=0, register dmem_* -> BUSY, count=0.
//  - BUSY: dmem_req=1, dmem_* stable. stall=~dmem_ack. On ack: load data captured, mb_wb__*
//    written (MEM src: extended load; store: rd_wen forced 0), dmem_req<=0, -> IDLE. Min
//    mem-op latency 2 cycles, +1 per wait cycle. No ack: count++, mb_wb__rd_wen<=0.
//  - count==BUS_TIMEOUT-1 w/o ack: dmem_req<=0, bus_err pulse, writeback dropped, stall=0, -> IDLE.
//  - Ack in IDLE ignored. rst mid-BUSY drops dmem_req immediately (async).
//  - Load extract: byte lane alu_y[1:0], half lane alu_y[1]; LB/LH sign-, LBU/LHU zero-extend to 32.
//  - Store: SB be=4'b0001<<a[1:0], wdata={4{rs2[7:0]}}; SH be=a[1]?1100:0011, wdata={2{rs2[15:0]}};
//    SW be=1111, wdata=rs2.
//  - Branch (IDLE, valid only): taken = JUMP | (BEQZ&zero) | (BNEZ&~zero); pipe_flush=taken,
//    pc_target=ex_mb__br_target. Never both flush and stall (branches carry mem_op NONE).
//  - x0: mb_wb__rd_wen never 1 for rd_addr==0.
// CONFIGURATION
//  MB_MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1 or LW/SW with a[1:0]!=0 -> no bus access,
//    bus_err pulse, writeback dropped, stall=0, stays IDLE.
//  Undefined: low address bits forced to natural alignment (a[0]=0 half, a[1:0]=0 word); no trap.
// TESTING
//  1 ALU op alu_y=0x1234, rd=5, rd_src ALU -> next cycle mb_wb={0x1234,5,1}, stall=0, no dmem_req.
//  2 LB alu_y=0x103, ack after 2 wait cycles, rdata=0x80FF_FF00 -> stall 3 cycles, wdata=0xFFFFFF80;
//    LBU same -> 0x00000080.
//  3 SH alu_y=0x202, rs2=0xABCD1234 -> be=1100, wdata=0x12341234, addr=0x200, mb_wb__rd_wen=0.
//  4 BNEZ zero=0 target=0x400 -> pipe_flush=1, pc_target=0x400; zero=1 -> no flush; pc=ffffffff -> no flush.
//  5 LW never acked -> dmem_req high 16 cycles, bus_err 1 cycle, stall drops, no writeback.
//  6 LW alu_y=0x6: with MB_MISALIGN_TRAP_EN bus_err, no req; without, addr=0x4 access; rst mid-BUSY -> req 0.

Source files
------------

// File: rtl/memory_branch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_branch : MB stage - data bus load/store, branch resolve, WB regs  |
// | Optional feature macro: MB_MISALIGN_TRAP_EN (trap misaligned accesses)   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module memory_branch #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_mb__alu_y,
  input  logic        ex_mb__alu_zero,
  input  logic [31:0] ex_mb__pc,
  input  logic [31:0] ex_mb__pc_4,
  input  logic [31:0] ex_mb__rs2_rdata,
  input  logic [31:0] ex_mb__br_target,
  input  logic [1:0]  ex_mb__br_op,
  input  logic [3:0]  ex_mb__mem_op,
  input  logic [1:0]  ex_mb__rd_src,
  input  logic [4:0]  ex_mb__rd_addr,
  input  logic        ex_mb__rd_wen,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        pipe_flush,
  output logic [31:0] pc_target,
  output logic        bus_err,
  output logic [31:0] mb_wb__rd_wdata,
  output logic [4:0]  mb_wb__rd_addr,
  output logic        mb_wb__rd_wen
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CW-1:0] C_COUNT_LAST = CW'(BUS_TIMEOUT - 1);
  localparam logic [31:0]   C_BUBBLE_PC  = 32'hffff_ffff;

  localparam logic [3:0] C_LB  = 4'd1;
  localparam logic [3:0] C_LH  = 4'd2;
  localparam logic [3:0] C_LW  = 4'd3;
  localparam logic [3:0] C_LBU = 4'd4;
  localparam logic [3:0] C_LHU = 4'd5;
  localparam logic [3:0] C_SB  = 4'd6;
  localparam logic [3:0] C_SH  = 4'd7;
  localparam logic [3:0] C_SW  = 4'd8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_count;
  logic [3:0]      r_mem_op;
  logic [1:0]      r_off;

  logic            w_valid;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_mem;
  logic            w_misaligned;
  logic            w_taken;
  logic [1:0]      w_off;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load_data;
  logic [31:0]     w_src_data;
  logic            w_last;

  assign w_valid    = (ex_mb__pc != C_BUBBLE_PC);
  assign w_is_load  = (ex_mb__mem_op >= C_LB) && (ex_mb__mem_op <= C_LHU);
  assign w_is_store = (ex_mb__mem_op >= C_SB) && (ex_mb__mem_op <= C_SW);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_last     = (r_count == C_COUNT_LAST);
  assign pc_target  = ex_mb__br_target;

`ifdef MB_MISALIGN_TRAP_EN
  always_comb begin
    w_misaligned = 1'b0;
    case (ex_mb__mem_op)
      C_LH, C_LHU, C_SH: w_misaligned = ex_mb__alu_y[0];
      C_LW, C_SW:        w_misaligned = |ex_mb__alu_y[1:0];
      default:           w_misaligned = 1'b0;
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // Lane offset is forced to natural alignment; with the trap enabled a
  // misaligned access never issues, so the same offset logic serves both builds.
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b0000;
    w_wdata = ex_mb__rs2_rdata;
    case (ex_mb__mem_op)
      C_LB, C_LBU, C_SB: begin
        w_off   = ex_mb__alu_y[1:0];
        w_be    = 4'b0001 << ex_mb__alu_y[1:0];
        w_wdata = {4{ex_mb__rs2_rdata[7:0]}};
      end
      C_LH, C_LHU, C_SH: begin
        w_off   = {ex_mb__alu_y[1], 1'b0};
        w_be    = ex_mb__alu_y[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_mb__rs2_rdata[15:0]}};
      end
      C_LW, C_SW: w_be = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (ex_mb__br_op)
      2'd1:    w_taken = ex_mb__alu_zero;
      2'd2:    w_taken = ~ex_mb__alu_zero;
      2'd3:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      2'd3:    w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_mem_op)
      C_LB:    w_load_data = {{24{w_byte[7]}}, w_byte};
      C_LBU:   w_load_data = {24'd0, w_byte};
      C_LH:    w_load_data = {{16{w_half[15]}}, w_half};
      C_LHU:   w_load_data = {16'd0, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    case (ex_mb__rd_src)
      2'd1:    w_src_data = w_load_data;
      2'd2:    w_src_data = ex_mb__pc_4;
      default: w_src_data = ex_mb__alu_y;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    pipe_flush   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          if (w_is_mem && !w_misaligned) begin
            stall        = 1'b1;
            w_state_next = S_BUSY;
          end else if (!w_is_mem) begin
            pipe_flush = w_taken;
          end
        end
      end
      S_BUSY: begin
        if (dmem_ack || w_last) begin
          w_state_next = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ex_mb__* is held by the stall, so writeback fields are taken straight
  // from the inputs in the ack cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_count         <= '0;
      r_mem_op        <= 4'd0;
      r_off           <= 2'd0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 32'd0;
      dmem_wdata      <= 32'd0;
      dmem_be         <= 4'd0;
      bus_err         <= 1'b0;
      mb_wb__rd_wdata <= 32'd0;
      mb_wb__rd_addr  <= 5'd0;
      mb_wb__rd_wen   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (!w_valid) begin
            mb_wb__rd_wen <= 1'b0;
          end else if (w_is_mem) begin
            mb_wb__rd_wen <= 1'b0;
            if (w_misaligned) begin
              bus_err <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= w_is_store;
              dmem_addr  <= {ex_mb__alu_y[31:2], 2'b00};
              dmem_wdata <= w_wdata;
              dmem_be    <= w_be;
              r_mem_op   <= ex_mb__mem_op;
              r_off      <= w_off;
            end
          end else begin
            mb_wb__rd_wdata <= w_src_data;
            mb_wb__rd_addr  <= ex_mb__rd_addr;
            mb_wb__rd_wen   <= ex_mb__rd_wen && (ex_mb__rd_addr != 5'd0);
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            dmem_req        <= 1'b0;
            mb_wb__rd_wdata <= w_src_data;
            mb_wb__rd_addr  <= ex_mb__rd_addr;
            mb_wb__rd_wen   <= ex_mb__rd_wen && (ex_mb__rd_addr != 5'd0) && !dmem_we;
          end else if (w_last) begin
            dmem_req      <= 1'b0;
            bus_err       <= 1'b1;
            mb_wb__rd_wen <= 1'b0;
          end else begin
            r_count       <= r_count + CW'(1);
            mb_wb__rd_wen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
